plic_hart_scan_arb: RTL
=======================

# plic_hart_scan_arb

Per-hart PLIC arbiter that scans all interrupt sources over several cycles, GRP_NUM sources per cycle, and tracks the winning pending, enabled source separately for M-mode and S-mode. The two winners are published with their IDs and priorities, and gated against per-mode thresholds to drive the hart's mint/sint requests. It sits between the per-hart register block (hreg) and the hart interrupt lines, one instance per hart. It replaces the fixed 1024-source, single-winner arbiter with a parametrised source count and scan width, and it adds dual-mode results.

## Interface
- INT_NUM, 1024: number of interrupt sources; ID 0 is reserved and never wins.
- PRIO_BIT, 5: priority width.
- ID_NUM, 10: ID width; must satisfy 2^ID_NUM >= INT_NUM.
- GRP_NUM, 32: sources examined per scan cycle; ROUNDS = ceil(INT_NUM/GRP_NUM).
- plic_clk  in  1  clock
- plicrst_b  in  1  reset, synchronous, active-low
- hreg_arbx_arb_start  in  1  request a new scan (pulse)
- hreg_arbx_arb_flush  in  1  abort scan, clear results
- hreg_arbx_mint_claim / hreg_arbx_sint_claim  in  1  consume the published M / S result
- hreg_arbx_int_en  in  INT_NUM  per-source enable for this hart
- hreg_arbx_int_mmode  in  INT_NUM  1 = source targets M-mode, 0 = S-mode
- hreg_arbx_prio_mth / hreg_arbx_prio_sth  in  PRIO_BIT  M / S thresholds
- kid_yy_int_req  in  INT_NUM  pending per source
- kid_yy_int_prio  in  INT_NUM*PRIO_BIT  priority per source, source i at [i*PRIO_BIT +: PRIO_BIT]
- int_sec_infor  in  INT_NUM  1 = secure source (only with PLIC_HART_ARB_SEC_EN)
- ctrl_xx_core_sec  in  1  hart is secure (only with PLIC_HART_ARB_SEC_EN)
- arbx_hreg_arb_start_ack  out  1  one-cycle pulse, start accepted
- arbx_hreg_claim_reg_ready  out  1  results valid
- arbx_hreg_mclaim_id / arbx_hreg_sclaim_id  out  ID_NUM  published winner IDs
- arbx_hreg_mclaim_prio / arbx_hreg_sclaim_prio  out  PRIO_BIT  published winner priorities
- arbx_hartx_mint_req / arbx_hartx_sint_req  out  1  interrupt requests to the hart

## Operation
- Eligibility: a source i is eligible when i != 0, req[i] = 1, en[i] = 1, and prio[i] != 0. The mode is taken from mmode[i].
- States: IDLE and SCAN. A 2-bit state register and a round counter of clog2(ROUNDS) bits.
- IDLE, start=1, flush=0:
  - ack pulses in the same cycle.
  - Next state is SCAN with round = 0.
  - Running bests are cleared to id 0, prio 0.
- SCAN, each cycle:
  - Group r covers IDs r*GRP_NUM to r*GRP_NUM+GRP_NUM-1. IDs at or above INT_NUM are ineligible.
  - Per mode, take the group's maximum priority. Ties go to the lowest index.
  - Replace the running best only on strictly greater priority. Lower IDs therefore win all ties.
- Last round (r = ROUNDS-1):
  - Publish both bests to the output registers and set ready = 1.
  - Return to IDLE. If a start arrived during SCAN (pending-start flag), go straight to SCAN round 0 instead, with ack pulsing then.
- start during SCAN: sets the pending flag, no ack. The running scan is not restarted.
- Flush, in any state:
  - Next state is IDLE; pending flag, published results and ready are cleared.
  - Flush beats a same-cycle start: the start is dropped and ack stays low.
- mint_claim: clears the published M id/prio to 0 next cycle. sint_claim does the same for S; the two claims are independent. ready stays high.
- Requests (combinational from published registers and threshold inputs):
  - mint_req = ready & (mclaim_prio > prio_mth).
  - sint_req = ready & (sclaim_prio > prio_sth).
- Reset: state IDLE; counter, flags, ids, prios and ready are 0; all outputs are 0.

## Timing
- Scan latency: from the start-accept cycle to ready is ROUNDS+1 edges. Results are visible in the cycle after the last round. The default is 33 cycles.
- Inputs are sampled in the round that covers them. A change to an already-scanned group takes effect only at the next scan.
- A claim in the same cycle as publish: the publish wins for that mode.
- Reset asserted mid-scan: the next edge returns the block to reset values.

## Configuration
- PLIC_HART_ARB_SEC_EN defined:
  - int_sec_infor and ctrl_xx_core_sec exist.
  - A source with int_sec_infor = 1 is ineligible when ctrl_xx_core_sec = 0.
- Not defined: the ports are absent and all sources are treated as non-secure.

## Structure
- Shared package plic_pkg: ROUNDS computation, state encoding (IDLE = 0, SCAN = 1), and a per-mode result struct {id, prio}.
- One sub-module, plic_grp_max: a combinational GRP_NUM-to-1 max-with-lowest-index tree. It is instantiated twice, once for M and once for S.

## Test plan
- Single source: INT_NUM = 64, GRP_NUM = 8. Source 37: S-mode, prio 3, sth = 1. Expect ack, then ready after 9 cycles with sclaim_id = 37, sint_req = 1, mint_req = 0.
- Tie-break and dual mode: sources 5 and 40, both M prio 7; source 12, S prio 2. Expect mclaim_id = 5 and sclaim_id = 12, both reqs high with thresholds 0.
- Threshold: mth = 7 with the winner at prio 7, so mint_req = 0. Lower mth to 6 and expect mint_req = 1 the next cycle, with no rescan needed.
- Flush and start collide on round 4: expect IDLE, ready = 0, ack never asserted. A later start completes normally.
- Claim and back-to-back start: a start during SCAN gives publish, then an immediate rescan with ack on the publish+0 cycle. mint_claim then zeros mclaim_id while sclaim_id is held.
- With the macro defined: core_sec = 0, source 9 secure at prio 7, source 10 non-secure at prio 1. Expect winner ID 10.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared PLIC arbiter definitions: scan round count, FSM encoding and the
// per-mode {id, prio} result record.
package plic_pkg;

  // Storage width of a result record; instances use the low ID_NUM / PRIO_BIT bits.
  localparam int PLIC_ID_MAX   = 16;
  localparam int PLIC_PRIO_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1
  } plic_state_e;

  typedef struct packed {
    logic [PLIC_ID_MAX-1:0]   id;
    logic [PLIC_PRIO_MAX-1:0] prio;
  } plic_res_t;

  function automatic int plic_rounds(input int int_num, input int grp_num);
    return (int_num + grp_num - 1) / grp_num;
  endfunction

endpackage

// File: rtl/plic_grp_max.sv
// Combinational GRP_NUM-to-1 maximum-priority selector; on equal priority the
// lower slot index wins. Invalid slots present priority 0.
module plic_grp_max #(
  parameter int GRP_NUM  = 32,
  parameter int PRIO_BIT = 5,
  parameter int IDX_W    = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1
) (
  input  logic [GRP_NUM-1:0]          vld_i,
  input  logic [GRP_NUM*PRIO_BIT-1:0] prio_i,
  output logic [PRIO_BIT-1:0]         max_prio_o,
  output logic [IDX_W-1:0]            max_idx_o
);

  localparam int LEAVES = 1 << IDX_W;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [PRIO_BIT-1:0] node_prio [NODES];
  logic [IDX_W-1:0]    node_idx  [NODES];

  // Heap-ordered binary tree: left children always hold lower slot indices,
  // so choosing left on ties yields the lowest-index winner.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      node_prio[n] = '0;
      node_idx[n]  = '0;
    end
    for (int g = 0; g < LEAVES; g++) begin
      node_idx[LEAVES-1+g] = IDX_W'(g);
      if (g < GRP_NUM) begin
        if (vld_i[g]) node_prio[LEAVES-1+g] = prio_i[g*PRIO_BIT +: PRIO_BIT];
      end
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      if (node_prio[2*n+1] >= node_prio[2*n+2]) begin
        node_prio[n] = node_prio[2*n+1];
        node_idx[n]  = node_idx[2*n+1];
      end else begin
        node_prio[n] = node_prio[2*n+2];
        node_idx[n]  = node_idx[2*n+2];
      end
    end
    max_prio_o = node_prio[0];
    max_idx_o  = node_idx[0];
  end

endmodule

// File: rtl/plic_hart_scan_arb.sv
// Per-hart PLIC arbiter: multi-cycle group scan with separate M/S winners.
// Optional secure filtering is enabled with `define PLIC_HART_ARB_SEC_EN.
module plic_hart_scan_arb
  import plic_pkg::*;
#(
  parameter int INT_NUM  = 1024,
  parameter int PRIO_BIT = 5,
  parameter int ID_NUM   = 10,
  parameter int GRP_NUM  = 32
) (
  input  logic                         plic_clk,
  input  logic                         plicrst_b,
  input  logic                         hreg_arbx_arb_start,
  input  logic                         hreg_arbx_arb_flush,
  input  logic                         hreg_arbx_mint_claim,
  input  logic                         hreg_arbx_sint_claim,
  input  logic [INT_NUM-1:0]           hreg_arbx_int_en,
  input  logic [INT_NUM-1:0]           hreg_arbx_int_mmode,
  input  logic [PRIO_BIT-1:0]          hreg_arbx_prio_mth,
  input  logic [PRIO_BIT-1:0]          hreg_arbx_prio_sth,
  input  logic [INT_NUM-1:0]           kid_yy_int_req,
  input  logic [INT_NUM*PRIO_BIT-1:0]  kid_yy_int_prio,
`ifdef PLIC_HART_ARB_SEC_EN
  input  logic [INT_NUM-1:0]           int_sec_infor,
  input  logic                         ctrl_xx_core_sec,
`endif
  output logic                         arbx_hreg_arb_start_ack,
  output logic                         arbx_hreg_claim_reg_ready,
  output logic [ID_NUM-1:0]            arbx_hreg_mclaim_id,
  output logic [ID_NUM-1:0]            arbx_hreg_sclaim_id,
  output logic [PRIO_BIT-1:0]          arbx_hreg_mclaim_prio,
  output logic [PRIO_BIT-1:0]          arbx_hreg_sclaim_prio,
  output logic                         arbx_hartx_mint_req,
  output logic                         arbx_hartx_sint_req
);

  localparam int ROUNDS = plic_rounds(INT_NUM, GRP_NUM);
  localparam int CNT_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int IDX_W  = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;

  plic_state_e state_q, state_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic pend_q, pend_d, ready_q, ready_d, ack;
  plic_res_t mbest_q, mbest_d, sbest_q, sbest_d;
  plic_res_t mpub_q, mpub_d, spub_q, spub_d;
  plic_res_t mcand, scand;

  logic [INT_NUM-1:0] sec_ok;
`ifdef PLIC_HART_ARB_SEC_EN
  assign sec_ok = ~int_sec_infor | {INT_NUM{ctrl_xx_core_sec}};
`else
  assign sec_ok = '1;
`endif

  // Eligibility tables laid out per round; slots beyond INT_NUM are padding.
  logic [ROUNDS-1:0][GRP_NUM-1:0]          elig_m, elig_s;
  logic [ROUNDS-1:0][GRP_NUM*PRIO_BIT-1:0] prio_tab;

  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    for (genvar g = 0; g < GRP_NUM; g++) begin : g_slot
      localparam int SID = r * GRP_NUM + g;
      if (SID < INT_NUM) begin : g_src
        logic elig;
        assign elig = (SID != 0) && kid_yy_int_req[SID] && hreg_arbx_int_en[SID]
                      && (kid_yy_int_prio[SID*PRIO_BIT +: PRIO_BIT] != '0) && sec_ok[SID];
        assign elig_m[r][g] = elig & hreg_arbx_int_mmode[SID];
        assign elig_s[r][g] = elig & ~hreg_arbx_int_mmode[SID];
        assign prio_tab[r][g*PRIO_BIT +: PRIO_BIT] = kid_yy_int_prio[SID*PRIO_BIT +: PRIO_BIT];
      end else begin : g_pad
        assign elig_m[r][g] = 1'b0;
        assign elig_s[r][g] = 1'b0;
        assign prio_tab[r][g*PRIO_BIT +: PRIO_BIT] = '0;
      end
    end
  end

  logic [PRIO_BIT-1:0] grp_mprio, grp_sprio;
  logic [IDX_W-1:0]    grp_midx, grp_sidx;

  plic_grp_max #(.GRP_NUM(GRP_NUM), .PRIO_BIT(PRIO_BIT), .IDX_W(IDX_W)) u_grp_m (
    .vld_i      (elig_m[round_q]),
    .prio_i     (prio_tab[round_q]),
    .max_prio_o (grp_mprio),
    .max_idx_o  (grp_midx)
  );

  plic_grp_max #(.GRP_NUM(GRP_NUM), .PRIO_BIT(PRIO_BIT), .IDX_W(IDX_W)) u_grp_s (
    .vld_i      (elig_s[round_q]),
    .prio_i     (prio_tab[round_q]),
    .max_prio_o (grp_sprio),
    .max_idx_o  (grp_sidx)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    pend_d  = pend_q;
    ready_d = ready_q;
    mbest_d = mbest_q;
    sbest_d = sbest_q;
    mpub_d  = mpub_q;
    spub_d  = spub_q;
    ack     = 1'b0;

    mcand = '0;
    mcand.id[ID_NUM-1:0] = ID_NUM'(round_q) * ID_NUM'(GRP_NUM) + ID_NUM'(grp_midx);
    mcand.prio[PRIO_BIT-1:0] = grp_mprio;
    scand = '0;
    scand.id[ID_NUM-1:0] = ID_NUM'(round_q) * ID_NUM'(GRP_NUM) + ID_NUM'(grp_sidx);
    scand.prio[PRIO_BIT-1:0] = grp_sprio;

    // Claims are applied first so that a same-cycle publish overrides them.
    if (hreg_arbx_mint_claim) mpub_d = '0;
    if (hreg_arbx_sint_claim) spub_d = '0;

    if (hreg_arbx_arb_flush) begin
      state_d = ST_IDLE;
      round_d = '0;
      pend_d  = 1'b0;
      ready_d = 1'b0;
      mpub_d  = '0;
      spub_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hreg_arbx_arb_start) begin
            ack     = 1'b1;
            state_d = ST_SCAN;
            round_d = '0;
            mbest_d = '0;
            sbest_d = '0;
          end
        end
        ST_SCAN: begin
          if (grp_mprio > mbest_q.prio[PRIO_BIT-1:0]) mbest_d = mcand;
          if (grp_sprio > sbest_q.prio[PRIO_BIT-1:0]) sbest_d = scand;
          if (round_q == CNT_W'(ROUNDS - 1)) begin
            mpub_d  = mbest_d;
            spub_d  = sbest_d;
            ready_d = 1'b1;
            pend_d  = 1'b0;
            if (pend_q || hreg_arbx_arb_start) begin
              ack     = 1'b1;
              round_d = '0;
              mbest_d = '0;
              sbest_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            round_d = round_q + 1'b1;
            if (hreg_arbx_arb_start) pend_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge plic_clk) begin
    if (!plicrst_b) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      mbest_q <= '0;
      sbest_q <= '0;
      mpub_q  <= '0;
      spub_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      mbest_q <= mbest_d;
      sbest_q <= sbest_d;
      mpub_q  <= mpub_d;
      spub_q  <= spub_d;
    end
  end

  assign arbx_hreg_arb_start_ack   = ack;
  assign arbx_hreg_claim_reg_ready = ready_q;
  assign arbx_hreg_mclaim_id       = mpub_q.id[ID_NUM-1:0];
  assign arbx_hreg_sclaim_id       = spub_q.id[ID_NUM-1:0];
  assign arbx_hreg_mclaim_prio     = mpub_q.prio[PRIO_BIT-1:0];
  assign arbx_hreg_sclaim_prio     = spub_q.prio[PRIO_BIT-1:0];
  assign arbx_hartx_mint_req = ready_q && (mpub_q.prio[PRIO_BIT-1:0] > hreg_arbx_prio_mth);
  assign arbx_hartx_sint_req = ready_q && (spub_q.prio[PRIO_BIT-1:0] > hreg_arbx_prio_sth);

  logic unused_ok;
  assign unused_ok = ^{mbest_q, sbest_q, mpub_q, spub_q, kid_yy_int_req[0],
                       hreg_arbx_int_en[0], hreg_arbx_int_mmode[0],
                       kid_yy_int_prio[PRIO_BIT-1:0], sec_ok[0]};

endmodule
